// File: rtl/spi_cfg_master.sv
// rtl/spi_cfg_master.sv - SPI Mode 0 write-only configuration master with command FIFO
module spi_cfg_master #(
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int CS_GAP     = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [6:0] cmd_addr_i,
    input  logic [7:0] cmd_data_i,
    output logic       sclk_o,
    output logic       copi_o,
    output logic       ncs_o,
    output logic       busy_o,
    output logic       frame_done_o,
    output logic [4:0] fifo_level_o
);
    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);
    localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);
    // GAP lasts CS_GAP-1 cycles; the IDLE cycle that follows completes the ncs-high gap.
    localparam logic [7:0]  GAP_LAST = (CS_GAP > 2) ? 8'(CS_GAP - 2) : 8'd0;

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_HIGH, S_LOW, S_HOLD, S_GAP} state_t;

    state_t      state_q;
    logic [7:0]  phase_q;
    logic [4:0]  bit_q;
    logic [14:0] shift_q;
    logic        sclk_q, copi_q, ncs_q, done_q;

    logic [14:0] mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q, level;
    logic        push, pop, phase_end;

    assign level       = wr_ptr_q - rd_ptr_q;
    assign cmd_ready_o = (level != FULL_LVL);
    assign push        = cmd_valid_i & cmd_ready_o;
    assign pop         = (state_q == S_IDLE) && (level != '0);
    assign phase_end   = (phase_q == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= {cmd_addr_i, cmd_data_i};
    end

    // shift_q holds the 15 bits after the constant write flag, which copi_q carries at SETUP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            phase_q <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            sclk_q  <= 1'b0;
            copi_q  <= 1'b0;
            ncs_q   <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        shift_q <= mem_q[rd_ptr_q[AW-1:0]];
                        copi_q  <= 1'b1;
                        ncs_q   <= 1'b0;
                        sclk_q  <= 1'b0;
                        phase_q <= '0;
                        bit_q   <= '0;
                        state_q <= S_SETUP;
                    end
                end
                S_SETUP, S_LOW: begin
                    if (phase_end) begin
                        phase_q <= '0;
                        sclk_q  <= 1'b1;
                        state_q <= S_HIGH;
                    end else begin
                        phase_q <= phase_q + 8'd1;
                    end
                end
                S_HIGH: begin
                    if (phase_end) begin
                        phase_q <= '0;
                        sclk_q  <= 1'b0;
                        bit_q   <= bit_q + 5'd1;
                        if (bit_q == 5'd15) begin
                            state_q <= S_HOLD;
                        end else begin
                            copi_q  <= shift_q[14];
                            shift_q <= {shift_q[13:0], 1'b0};
                            state_q <= S_LOW;
                        end
                    end else begin
                        phase_q <= phase_q + 8'd1;
                    end
                end
                S_HOLD: begin
                    if (phase_end) begin
                        phase_q <= '0;
                        ncs_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= S_GAP;
                    end else begin
                        phase_q <= phase_q + 8'd1;
                    end
                end
                S_GAP: begin
                    if (phase_q == GAP_LAST) begin
                        phase_q <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        phase_q <= phase_q + 8'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign sclk_o       = sclk_q;
    assign copi_o       = copi_q;
    assign ncs_o        = ncs_q;
    assign frame_done_o = done_q;
    assign busy_o       = (state_q != S_IDLE) || (level != '0);
    assign fifo_level_o = 5'(level);
endmodule

// File: tb/tb_spi_cfg_master.sv
// tb/tb_spi_cfg_master.sv - scoreboard bench for spi_cfg_master with a peripheral-side monitor
module tb_spi_cfg_master;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       cmd_valid, cmd_ready;
    logic [6:0] cmd_addr;
    logic [7:0] cmd_data;
    logic       sclk, copi, ncs, busy, frame_done;
    logic [4:0] fifo_level;

    logic       v7, r7;
    logic [6:0] a7;
    logic [7:0] d7;
    logic       sclk7, copi7, ncs7, busy7, done7;
    logic [4:0] lvl7;

    spi_cfg_master #(.CLK_DIV(4), .FIFO_DEPTH(4), .CS_GAP(8)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_addr_i(cmd_addr), .cmd_data_i(cmd_data), .sclk_o(sclk), .copi_o(copi),
        .ncs_o(ncs), .busy_o(busy), .frame_done_o(frame_done), .fifo_level_o(fifo_level)
    );

    spi_cfg_master #(.CLK_DIV(7), .FIFO_DEPTH(4), .CS_GAP(8)) dut7 (
        .clk(clk), .rst_n(rst_n), .cmd_valid_i(v7), .cmd_ready_o(r7),
        .cmd_addr_i(a7), .cmd_data_i(d7), .sclk_o(sclk7), .copi_o(copi7),
        .ncs_o(ncs7), .busy_o(busy7), .frame_done_o(done7), .fifo_level_o(lvl7)
    );

    int total = 0;
    int bad   = 0;

    logic [15:0] exp_q[$];
    logic [15:0] exp7_q[$];

    // Peripheral model for the CLK_DIV=4 instance: samples copi on sclk rises, commits 16-bit frames only.
    logic [15:0] cap_word[$];
    int          cap_bits[$], cap_len[$], cap_gap[$];
    logic [7:0]  model_regs [128];
    logic        m_init = 1'b0;
    logic [15:0] m_shift;
    int          m_bits, m_low, m_high, done_cnt, done_bad, copi_viol;
    logic        m_sclk_prev, m_ncs_prev, m_copi_prev;

    always @(negedge clk) begin
        if (!rst_n) begin
            if (!m_init) begin
                for (int i = 0; i < 128; i++) model_regs[i] = 8'h00;
                done_cnt = 0; done_bad = 0; copi_viol = 0; m_init = 1'b1;
            end
            m_shift = '0; m_bits = 0; m_low = 0; m_high = 0;
            m_sclk_prev = 1'b0; m_ncs_prev = 1'b1; m_copi_prev = 1'b0;
        end else begin
            if (frame_done) done_cnt++;
            if (frame_done && !(ncs && !m_ncs_prev)) done_bad++;
            if (!ncs) begin
                if (m_ncs_prev) begin cap_gap.push_back(m_high); m_high = 0; end
                m_low++;
                if (sclk && m_sclk_prev && copi !== m_copi_prev) copi_viol++;
                if (sclk && !m_sclk_prev) begin m_shift = {m_shift[14:0], copi}; m_bits++; end
            end else begin
                m_high++;
                if (!m_ncs_prev) begin
                    cap_word.push_back(m_shift); cap_bits.push_back(m_bits); cap_len.push_back(m_low);
                    if (m_bits == 16 && m_shift[15]) model_regs[m_shift[14:8]] = m_shift[7:0];
                    m_shift = '0; m_bits = 0; m_low = 0;
                end
            end
            m_sclk_prev = sclk; m_ncs_prev = ncs; m_copi_prev = copi;
        end
    end

    logic [15:0] s7;
    int          low7, run7;
    logic        s7_prev, n7_prev;
    int          hi_runs[$], lo_runs[$], len7[$];
    logic [15:0] word7[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            s7 = '0; low7 = 0; run7 = 0; s7_prev = 1'b0; n7_prev = 1'b1;
        end else begin
            if (!ncs7) begin
                low7++;
                if (n7_prev) run7 = 1;
                else if (sclk7 == s7_prev) run7++;
                else begin
                    if (s7_prev) hi_runs.push_back(run7); else lo_runs.push_back(run7);
                    run7 = 1;
                end
                if (sclk7 && !s7_prev) s7 = {s7[14:0], copi7};
            end else if (!n7_prev) begin
                lo_runs.push_back(run7); len7.push_back(low7); word7.push_back(s7);
                low7 = 0; s7 = '0;
            end
            s7_prev = sclk7; n7_prev = ncs7;
        end
    end

    task automatic push_cmd(input logic [6:0] a, input logic [7:0] d);
        cmd_addr = a; cmd_data = d; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_caps(input int n, input int budget);
        for (int i = 0; i < budget && cap_word.size() < n; i++) @(negedge clk);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && busy; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        int nb;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_data = '0;
        v7 = 1'b0; a7 = '0; d7 = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({ncs, sclk, copi, busy, frame_done, cmd_ready} !== 6'b100001) begin
            bad++; $display("FAIL reset_outputs: got %b expected 100001", {ncs, sclk, copi, busy, frame_done, cmd_ready});
        end
        total++;
        if (fifo_level !== 5'd0) begin bad++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end

        @(posedge clk); #1;
        push_cmd(7'h02, 8'h77);
        for (int i = 0; i < 400 && m_bits < 5; i++) @(posedge clk);
        total++;
        if (m_bits < 5) begin bad++; $display("FAIL reset_midframe_reach: got %0d bits expected 5", m_bits); end
        nb = cap_word.size();
        #1 rst_n = 1'b0;
        #1;
        total++;
        if ({ncs, sclk} !== 2'b10) begin bad++; $display("FAIL reset_async: got ncs/sclk %b expected 10", {ncs, sclk}); end
        total++;
        if (fifo_level !== 5'd0) begin bad++; $display("FAIL reset_async_level: got %0d expected 0", fifo_level); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (300) @(negedge clk);
        total++;
        if (cap_word.size() != nb) begin bad++; $display("FAIL reset_no_frame: got %0d frames expected %0d", cap_word.size(), nb); end
        total++;
        if (model_regs[2] !== 8'h00) begin bad++; $display("FAIL reset_no_write: got %0h expected 0", model_regs[2]); end
    endtask

    task automatic test_single();
        int base, d0;
        base = cap_word.size();
        d0 = done_cnt;
        @(negedge clk);
        push_cmd(7'h04, 8'hA5);
        exp_q.push_back(16'h84A5);
        total++;
        if (ncs !== 1'b1) begin bad++; $display("FAIL single_ncs_accept: got %b expected 1", ncs); end
        @(posedge clk); #1;
        total++;
        if (ncs !== 1'b0) begin bad++; $display("FAIL single_ncs_fall: got %b expected 0", ncs); end
        wait_caps(base + 1, 1000);
        total++;
        if (cap_word.size() != base + 1) begin
            bad++; $display("FAIL single_frame_count: got %0d expected %0d", cap_word.size(), base + 1);
        end else begin
            logic [15:0] e;
            e = exp_q.pop_front();
            total++;
            if (cap_word[base] !== e) begin bad++; $display("FAIL single_word: got %h expected %h", cap_word[base], e); end
            total++;
            if (cap_bits[base] != 16) begin bad++; $display("FAIL single_bits: got %0d expected 16", cap_bits[base]); end
            total++;
            if (cap_len[base] != 132) begin bad++; $display("FAIL single_ncs_len: got %0d expected 132", cap_len[base]); end
        end
        total++;
        if (done_cnt - d0 != 1) begin bad++; $display("FAIL single_done: got %0d pulses expected 1", done_cnt - d0); end
        total++;
        if (model_regs[4] !== 8'hA5) begin bad++; $display("FAIL single_model: got %h expected a5", model_regs[4]); end
        wait_idle();
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_end: got %b expected 0", busy); end
    endtask

    task automatic test_back_to_back();
        int base, gbase, busy_low;
        logic [7:0] dat [3];
        dat[0] = 8'hFF; dat[1] = 8'h0F; dat[2] = 8'h3C;
        base = cap_word.size();
        gbase = cap_gap.size();
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cmd_addr = 7'(i); cmd_data = dat[i];
            exp_q.push_back({1'b1, 7'(i), dat[i]});
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        busy_low = 0;
        for (int i = 0; i < 1500 && cap_word.size() < base + 3; i++) begin
            @(negedge clk);
            if (!busy) busy_low++;
        end
        total++;
        if (cap_word.size() != base + 3) begin
            bad++; $display("FAIL b2b_frame_count: got %0d expected %0d", cap_word.size() - base, 3);
        end else begin
            for (int i = 0; i < 3; i++) begin
                logic [15:0] e;
                e = exp_q.pop_front();
                total++;
                if (cap_word[base+i] !== e) begin bad++; $display("FAIL b2b_word%0d: got %h expected %h", i, cap_word[base+i], e); end
                total++;
                if (cap_len[base+i] != 132) begin bad++; $display("FAIL b2b_len%0d: got %0d expected 132", i, cap_len[base+i]); end
            end
            for (int i = 1; i < 3; i++) begin
                total++;
                if (cap_gap[gbase+i] != 8) begin bad++; $display("FAIL b2b_gap%0d: got %0d expected 8", i, cap_gap[gbase+i]); end
            end
        end
        total++;
        if (busy_low != 0) begin bad++; $display("FAIL b2b_busy: got %0d idle samples expected 0", busy_low); end
        total++;
        if ({model_regs[0], model_regs[1], model_regs[2]} !== 24'hFF0F3C) begin
            bad++; $display("FAIL b2b_model: got %h expected ff0f3c", {model_regs[0], model_regs[1], model_regs[2]});
        end
        total++;
        if (done_bad != 0 || copi_viol != 0) begin
            bad++; $display("FAIL b2b_invariants: got done_bad=%0d copi_viol=%0d expected 0", done_bad, copi_viol);
        end
        wait_idle();
    endtask

    task automatic test_fifo_full();
        int base, k, acc;
        base = cap_word.size();
        @(negedge clk);
        push_cmd(7'h10, 8'h11);
        exp_q.push_back(16'h9011);
        for (int i = 0; i < 10 && ncs; i++) @(negedge clk);
        @(posedge clk); #1;
        k = 0; acc = 0;
        for (int c = 0; c < 6; c++) begin
            cmd_valid = 1'b1; cmd_addr = 7'h20 + 7'(k); cmd_data = 8'h40 + 8'(k);
            @(negedge clk);
            if (cmd_ready) begin
                exp_q.push_back({1'b1, cmd_addr, cmd_data});
                acc++; k++;
            end
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        total++;
        if (acc != 4) begin bad++; $display("FAIL full_accepted: got %0d expected 4", acc); end
        total++;
        if (cmd_ready !== 1'b0 || fifo_level !== 5'd4) begin
            bad++; $display("FAIL full_ready: got ready=%b level=%0d expected ready=0 level=4", cmd_ready, fifo_level);
        end
        for (int i = 0; i < 400 && !cmd_ready; i++) @(negedge clk);
        total++;
        if ({cmd_ready, ncs, fifo_level} !== {2'b10, 5'd3}) begin
            bad++; $display("FAIL full_ready_return: got ready=%b ncs=%b level=%0d expected 1 0 3", cmd_ready, ncs, fifo_level);
        end
        wait_caps(base + 5, 4000);
        total++;
        if (cap_word.size() != base + 5) begin
            bad++; $display("FAIL full_frame_count: got %0d expected 5", cap_word.size() - base);
        end else begin
            for (int i = 0; i < 5; i++) begin
                logic [15:0] e;
                e = exp_q.pop_front();
                total++;
                if (cap_word[base+i] !== e) begin bad++; $display("FAIL full_word%0d: got %h expected %h", i, cap_word[base+i], e); end
            end
        end
        wait_idle();
    endtask

    task automatic test_push_pop();
        int base, gbase;
        base = cap_word.size();
        gbase = cap_gap.size();
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_addr = 7'h30; cmd_data = 8'h5A;
        exp_q.push_back(16'hB05A);
        @(posedge clk); #1;
        total++;
        if (fifo_level !== 5'd1) begin bad++; $display("FAIL pushpop_level_first: got %0d expected 1", fifo_level); end
        cmd_addr = 7'h31; cmd_data = 8'hC3;
        exp_q.push_back(16'hB1C3);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        total++;
        if (fifo_level !== 5'd1 || ncs !== 1'b0) begin
            bad++; $display("FAIL pushpop_level: got level=%0d ncs=%b expected 1 0", fifo_level, ncs);
        end
        wait_caps(base + 2, 1500);
        total++;
        if (cap_word.size() != base + 2) begin
            bad++; $display("FAIL pushpop_frame_count: got %0d expected 2", cap_word.size() - base);
        end else begin
            for (int i = 0; i < 2; i++) begin
                logic [15:0] e;
                e = exp_q.pop_front();
                total++;
                if (cap_word[base+i] !== e) begin bad++; $display("FAIL pushpop_word%0d: got %h expected %h", i, cap_word[base+i], e); end
            end
            total++;
            if (cap_gap[gbase+1] != 8) begin bad++; $display("FAIL pushpop_gap: got %0d expected 8", cap_gap[gbase+1]); end
        end
        total++;
        if (model_regs[7'h31] !== 8'hC3) begin bad++; $display("FAIL pushpop_model: got %h expected c3", model_regs[7'h31]); end
        wait_idle();
    endtask

    task automatic test_clk_div();
        int hi_bad, lo_bad;
        @(posedge clk); #1;
        v7 = 1'b1; a7 = 7'h05; d7 = 8'h3C;
        exp7_q.push_back({1'b1, 7'h05, 8'h3C});
        @(posedge clk); #1;
        v7 = 1'b0;
        for (int i = 0; i < 1000 && word7.size() < 1; i++) @(negedge clk);
        total++;
        if (word7.size() != 1) begin
            bad++; $display("FAIL div7_frame_count: got %0d expected 1", word7.size());
        end else begin
            logic [15:0] e;
            e = exp7_q.pop_front();
            total++;
            if (word7[0] !== e) begin bad++; $display("FAIL div7_word: got %h expected %h", word7[0], e); end
            total++;
            if (len7[0] != 231) begin bad++; $display("FAIL div7_ncs_len: got %0d expected 231", len7[0]); end
        end
        total++;
        if (hi_runs.size() != 16 || lo_runs.size() != 17) begin
            bad++; $display("FAIL div7_phase_count: got hi=%0d lo=%0d expected 16 17", hi_runs.size(), lo_runs.size());
        end
        hi_bad = 0; lo_bad = 0;
        foreach (hi_runs[i]) if (hi_runs[i] != 7) hi_bad++;
        foreach (lo_runs[i]) if (lo_runs[i] != 7) lo_bad++;
        total++;
        if (hi_bad != 0 || lo_bad != 0) begin
            bad++; $display("FAIL div7_phase_len: got %0d high and %0d low phases not 7 cycles expected 0", hi_bad, lo_bad);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got time limit expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_fifo_full();
        test_push_pop();
        test_clk_div();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
